rv_alu_issue: RTL and testbench

RV_ALU_ISSUE -- requirements
Module: rv_alu_issue

---
 rtl/rv_alu_issue.sv | 204 ++++++++++++++++++++
 tb/tb_rv_alu_issue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_alu_issue.sv
// RV32I ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU operands and a control code,
// then buffers them in a two-entry valid/ready pipeline (OUT + SKID) with a registered ready.
//
// state   | meaning
// --------+-------------------------------------------
// S_EMPTY | no valid entry, out_valid_o=0, in_ready_o=1
// S_ONE   | OUT valid, SKID empty, in_ready_o=1
// S_FULL  | OUT and SKID valid, in_ready_o=0
module rv_alu_issue (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [3:0]  aluctrl_o,
  output logic [4:0]  rd_o,
  output logic [31:0] pc_o,
  output logic        illegal_o
);

  localparam logic [3:0] ALU_SUB  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        ill;
  } entry_t;

  localparam entry_t ENTRY_RST = '{a: 32'd0, b: 32'd0, ctrl: ALU_ADD, rd: 5'd0, pc: 32'd0, ill: 1'b0};

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t state_q;
  entry_t out_q, skid_q, dec;
  logic   accept, drain;

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_u, shamt;
  logic [31:0] a_val, b_val;
  logic [3:0]  ctrl;
  logic        legal;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_u  = {instr_i[31:12], 12'b0};
  assign shamt  = {27'b0, instr_i[24:20]};

  always_comb begin
    a_val = 32'd0;
    b_val = 32'd0;
    ctrl  = ALU_ADD;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_val = rs1_data_i;
        b_val = rs2_data_i;
        if (funct7 == 7'b0000000) begin
          legal = 1'b1;
          case (funct3)
            3'd0:    ctrl = ALU_ADD;
            3'd1:    ctrl = ALU_SLL;
            3'd2:    ctrl = ALU_SLT;
            3'd3:    ctrl = ALU_SLTU;
            3'd4:    ctrl = ALU_XOR;
            3'd5:    ctrl = ALU_SRL;
            3'd6:    ctrl = ALU_OR;
            default: ctrl = ALU_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          legal = (funct3 == 3'd0) || (funct3 == 3'd5);
          ctrl  = (funct3 == 3'd0) ? ALU_SUB : ALU_SRA;
        end
      end
      OPC_OPIMM: begin
        a_val = rs1_data_i;
        b_val = imm_i;
        legal = 1'b1;
        case (funct3)
          3'd0: ctrl = ALU_ADD;
          3'd1: begin
            ctrl  = ALU_SLL;
            b_val = shamt;
            legal = (funct7 == 7'b0000000);
          end
          3'd2: ctrl = ALU_SLT;
          3'd3: ctrl = ALU_SLTU;
          3'd4: ctrl = ALU_XOR;
          3'd5: begin
            b_val = shamt;
            ctrl  = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          3'd6:    ctrl = ALU_OR;
          default: ctrl = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        b_val = imm_u;
        legal = 1'b1;
      end
      OPC_AUIPC: begin
        a_val = pc_i;
        b_val = imm_u;
        legal = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Anything not decodable still travels down the pipe, but as a harmless ADD of zeros.
    dec.a    = legal ? a_val : 32'd0;
    dec.b    = legal ? b_val : 32'd0;
    dec.ctrl = legal ? ctrl : ALU_ADD;
    dec.rd   = instr_i[11:7];
    dec.pc   = pc_i;
    dec.ill  = ~legal;
  end

  assign accept = in_valid_i && in_ready_o;
  assign drain  = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= S_EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      out_q       <= ENTRY_RST;
      skid_q      <= ENTRY_RST;
    end else if (flush_i) begin
      state_q     <= S_EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            out_q       <= dec;
            out_valid_o <= 1'b1;
            state_q     <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && !drain) begin
            skid_q     <= dec;
            in_ready_o <= 1'b0;
            state_q    <= S_FULL;
          end else if (accept) begin
            out_q <= dec;
          end else if (drain) begin
            out_valid_o <= 1'b0;
            state_q     <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (drain) begin
            out_q      <= skid_q;
            in_ready_o <= 1'b1;
            state_q    <= S_ONE;
          end
        end
        default: begin
          state_q     <= S_EMPTY;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
        end
      endcase
    end
  end

  assign a_o       = out_q.a;
  assign b_o       = out_q.b;
  assign aluctrl_o = out_q.ctrl;
  assign rd_o      = out_q.rd;
  assign pc_o      = out_q.pc;
  assign illegal_o = out_q.ill;

endmodule

// File: tb/tb_rv_alu_issue.sv
// Directed + random bench for rv_alu_issue; expected entries come from a hand-decoded
// instruction table and are matched against the DUT output stream through a queue.
module tb_rv_alu_issue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] a_o, b_o, pc_o;
  logic [3:0]  aluctrl_o;
  logic [4:0]  rd_o;
  logic        illegal_o;

  rv_alu_issue dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .a_o(a_o), .b_o(b_o), .aluctrl_o(aluctrl_o), .rd_o(rd_o), .pc_o(pc_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // asel: 0 zero, 1 rs1, 2 pc ; bsel: 0 bimm, 1 rs2
  typedef struct {
    logic [31:0] instr;
    int          asel;
    int          bsel;
    logic [31:0] bimm;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        ill;
  } tv_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  localparam int NTV = 14;
  tv_t  tv [NTV];
  exp_t sb [$];
  exp_t cur_exp, exp_a;
  int   errors = 0;
  int   checks = 0;
  int   delivered = 0;
  logic last_in_fire;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int idx, input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc);
    in_valid_i   = 1'b1;
    instr_i      = tv[idx].instr;
    rs1_data_i   = rs1;
    rs2_data_i   = rs2;
    pc_i         = pc;
    cur_exp.a    = (tv[idx].asel == 1) ? rs1 : (tv[idx].asel == 2) ? pc : 32'd0;
    cur_exp.b    = (tv[idx].bsel == 1) ? rs2 : tv[idx].bimm;
    cur_exp.ctrl = tv[idx].ctrl;
    cur_exp.rd   = tv[idx].rd;
    cur_exp.pc   = pc;
    cur_exp.ill  = tv[idx].ill;
  endtask

  // Score the transfers that happen at the coming edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    logic in_fire, out_fire;
    in_fire      = in_valid_i && in_ready_o;
    out_fire     = out_valid_o && out_ready_i;
    last_in_fire = in_fire;
    if (!rst_ni || flush_i) begin
      sb.delete();
    end else begin
      if (out_fire) begin
        chk("sb_unexpected_output", {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          delivered++;
          chk("sb_a", a_o, e.a);
          chk("sb_b", b_o, e.b);
          chk("sb_ctrl", {28'd0, aluctrl_o}, {28'd0, e.ctrl});
          chk("sb_rd", {27'd0, rd_o}, {27'd0, e.rd});
          chk("sb_pc", pc_o, e.pc);
          chk("sb_ill", {31'd0, illegal_o}, {31'd0, e.ill});
        end
      end
      if (in_fire) sb.push_back(cur_exp);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid_o}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready_o}, 32'd1);
    chk({tag, "_a"}, a_o, 32'd0);
    chk({tag, "_b"}, b_o, 32'd0);
    chk({tag, "_pc"}, pc_o, 32'd0);
    chk({tag, "_ctrl"}, {28'd0, aluctrl_o}, 32'd1);
    chk({tag, "_rd"}, {27'd0, rd_o}, 32'd0);
    chk({tag, "_ill"}, {31'd0, illegal_o}, 32'd0);
  endtask

  task automatic drain_all(input string tag);
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 20 && (sb.size() != 0 || out_valid_o); i++) tick();
    chk({tag, "_leftover"}, sb.size(), 32'd0);
    chk({tag, "_idle_valid"}, {31'd0, out_valid_o}, 32'd0);
  endtask

  initial begin
    tv[0]  = '{32'h002081B3, 1, 1, 32'h0,        4'b0001, 5'd3, 1'b0}; // add x3,x1,x2
    tv[1]  = '{32'h402081B3, 1, 1, 32'h0,        4'b0000, 5'd3, 1'b0}; // sub
    tv[2]  = '{32'h40435293, 1, 0, 32'd4,        4'b0110, 5'd5, 1'b0}; // srai x5,x6,4
    tv[3]  = '{32'hFE435293, 0, 0, 32'h0,        4'b0001, 5'd5, 1'b1}; // srai, bad funct7
    tv[4]  = '{32'h12345097, 2, 0, 32'h12345000, 4'b0001, 5'd1, 1'b0}; // auipc x1
    tv[5]  = '{32'h123450B7, 0, 0, 32'h12345000, 4'b0001, 5'd1, 1'b0}; // lui x1
    tv[6]  = '{32'hFFF08113, 1, 0, 32'hFFFFFFFF, 4'b0001, 5'd2, 1'b0}; // addi x2,x1,-1
    tv[7]  = '{32'h0020E233, 1, 1, 32'h0,        4'b1000, 5'd4, 1'b0}; // or
    tv[8]  = '{32'h0020B233, 1, 1, 32'h0,        4'b0100, 5'd4, 1'b0}; // sltu
    tv[9]  = '{32'h00112023, 0, 0, 32'h0,        4'b0001, 5'd0, 1'b1}; // sw: not ours
    tv[10] = '{32'h01F09393, 1, 0, 32'd31,       4'b0010, 5'd7, 1'b0}; // slli x7,x1,31
    tv[11] = '{32'h4020D1B3, 1, 1, 32'h0,        4'b0110, 5'd3, 1'b0}; // sra
    tv[12] = '{32'h402091B3, 0, 0, 32'h0,        4'b0001, 5'd3, 1'b1}; // sll with funct7=0x20
    tv[13] = '{32'h7F00F113, 1, 0, 32'h7F0,      4'b1001, 5'd2, 1'b0}; // andi x2,x1,0x7f0

    rst_ni = 1'b0; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
    instr_i = 32'd0; pc_i = 32'd0; rs1_data_i = 32'd0; rs2_data_i = 32'd0;
    last_in_fire = 1'b0;
    @(posedge clk_i); #1;
    tick();
    check_reset_values("reset");
    rst_ni = 1'b1;
    tick();

    // Single ADD, one-cycle latency
    out_ready_i = 1'b1;
    drive(0, 32'd5, 32'd7, 32'h40);
    tick();
    in_valid_i = 1'b0;
    chk("add_valid", {31'd0, out_valid_o}, 32'd1);
    chk("add_a", a_o, 32'd5);
    chk("add_b", b_o, 32'd7);
    chk("add_ctrl", {28'd0, aluctrl_o}, 32'd1);
    chk("add_rd", {27'd0, rd_o}, 32'd3);
    tick();
    chk("add_empty_after", {31'd0, out_valid_o}, 32'd0);

    // Back-to-back decode coverage with the consumer always ready
    drive(2, 32'h80000000, 32'h0, 32'h104); tick();
    chk("srai_ctrl", {28'd0, aluctrl_o}, 32'h6);
    chk("srai_b", b_o, 32'd4);
    chk("srai_ill", {31'd0, illegal_o}, 32'd0);
    drive(3, 32'h80000000, 32'h0, 32'h108); tick();
    chk("srai_bad_ill", {31'd0, illegal_o}, 32'd1);
    chk("srai_bad_ctrl", {28'd0, aluctrl_o}, 32'd1);
    drive(4, 32'h11, 32'h22, 32'h100); tick();
    chk("auipc_a", a_o, 32'h100);
    chk("auipc_b", b_o, 32'h12345000);
    drive(5, 32'h11, 32'h22, 32'h100); tick();
    chk("lui_a", a_o, 32'd0);
    chk("lui_b", b_o, 32'h12345000);
    for (int i = 6; i < NTV; i++) begin
      drive(i, 32'hA5A5_0000 + 32'(i), 32'h0F0F_0000 + 32'(i), 32'h200 + 32'(4 * i));
      tick();
    end
    drain_all("b2b");

    // Back-pressure: two accepted, third stalls until ready reopens
    out_ready_i = 1'b0;
    drive(0, 32'd1, 32'd2, 32'h300); exp_a = cur_exp; tick();
    drive(7, 32'd3, 32'd4, 32'h304); tick();
    chk("bp_ready_low", {31'd0, in_ready_o}, 32'd0);
    drive(2, 32'h80000000, 32'd0, 32'h308);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_third_blocked", {31'd0, last_in_fire}, 32'd0);
      chk("bp_hold_a", a_o, exp_a.a);
      chk("bp_hold_pc", pc_o, exp_a.pc);
      chk("bp_hold_ctrl", {28'd0, aluctrl_o}, {28'd0, exp_a.ctrl});
    end
    out_ready_i = 1'b1;
    begin
      logic got;
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
        tick();
        got = last_in_fire;
      end
      chk("bp_third_accepted", {31'd0, got}, 32'd1);
    end
    drain_all("bp");

    // Flush while FULL with a new instruction offered
    out_ready_i = 1'b0;
    drive(1, 32'd9, 32'd8, 32'h400); tick();
    drive(6, 32'd9, 32'd8, 32'h404); tick();
    drive(11, 32'd9, 32'd8, 32'h408);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    chk("flush_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_no_output", {31'd0, out_valid_o}, 32'd0);
    end

    // Reset for one cycle while FULL
    out_ready_i = 1'b0;
    drive(4, 32'd1, 32'd1, 32'h500); tick();
    drive(13, 32'd1, 32'd1, 32'h504); tick();
    in_valid_i = 1'b0;
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check_reset_values("midrst");
    out_ready_i = 1'b1;
    tick();
    chk("midrst_no_output", {31'd0, out_valid_o}, 32'd0);

    // Random valid/ready stress with occasional flush
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) != 0)
        drive(int'($urandom_range(0, NTV - 1)), $urandom, $urandom, $urandom);
      else
        in_valid_i = 1'b0;
      out_ready_i = ($urandom_range(0, 2) != 0);
      flush_i     = ($urandom_range(0, 149) == 0);
      tick();
    end
    flush_i = 1'b0;
    drain_all("stress");
    chk("stress_delivered_some", {31'd0, delivered > 500}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
